fetch_cycle: RTL and testbench
==============================

Name: fetch_cycle

Overview:
- Instruction fetch stage. Sits directly upstream of the decode stage and feeds it the instruction word, its PC and a valid flag.
- Owns the PC and a variable-latency req/ack instruction-memory interface.
- Has a one-entry skid buffer so decode stalls never lose a returned instruction.
- Handles branch/jump redirects with flush and in-flight-response discard.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- PC_INC, 2, address increment per sequential instruction (byte-addressed 16-bit instructions).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  16  fetch address; stable while imem_req high.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  input  16  instruction word returned.
- stall  input  1  decode cannot accept; hold outputs.
- redirect  input  1  flush and refetch from redirect_pc.
- redirect_pc  input  16  new fetch target.
- ir  output  16  instruction to decode.
- pcout  output  16  PC of ir.
- valid  output  1  ir/pcout hold a live instruction.

Behaviour:
- Reset values: ir=16'h0000, pcout=16'h0000, valid=0, imem_req=0, imem_addr=RESET_PC, skid empty, state=IDLE.
- Consume rule: decode takes the output at a posedge where valid=1 and stall=0.
- FSM states: IDLE, REQ, DROP, FULL.
- IDLE: imem_req=0 for exactly one cycle after reset deasserts, then go to REQ with imem_addr=RESET_PC. Any imem_ack seen in IDLE is ignored.
- REQ: imem_req=1. On imem_ack:
  - Place the instruction in the output regs if the output is empty or being consumed this edge; otherwise place it in the skid.
  - Advance imem_addr by PC_INC (16-bit wrap: 16'hFFFE+2 gives 16'h0000).
  - Go to FULL if the output and skid are both occupied afterwards; otherwise stay in REQ.
- Latency: instruction appears on ir with valid=1 on the edge after imem_ack, provided the output was free.
- FULL: imem_req=0. When the output is consumed, move the skid into the output and return to REQ at the already-advanced address.
- Ordering: the skid always drains before newer data; program order is never violated.
- Redirect has priority over stall and over ack data:
  - At the redirect edge: valid=0, skid cleared, target := redirect_pc.
  - From REQ without ack in the same cycle: go to DROP. imem_req stays high on the old imem_addr until ack (bus contract). Returned data is discarded; then go to REQ with imem_addr=target.
  - From REQ with ack in the same cycle: discard the data and go to REQ with imem_addr=redirect_pc next cycle.
  - From FULL or IDLE: go to REQ at redirect_pc.
  - In DROP: a further redirect updates the target only; the last one wins.
- pcout equals the imem_addr used for that instruction. ir/pcout do not change while valid=1 and stall=1.
- Reset asserted mid-request: all state clears at once and imem_req drops asynchronously. Memory is reset by the same signal.
- Throughput: one instruction per cycle with a zero-wait memory (ack in the same cycle as req) and no stall.

Decomposition:
- Shared package holds:
  - Fetch state encoding (IDLE, REQ, DROP, FULL, 2 bits).
  - Width constants: INST_W=16, ADDR_W=16, REG_IDX_W=4.
  - NOP encoding 16'h0000.
- One natural sub-module: fetch_skid_buffer. It is the one-entry {inst, pc, valid} holding register with push/pop/flush, reused later for other stage boundaries.

Test Plan:
- Reset, zero-wait memory returning addr^16'hA5A5, no stall -> valid rises 2 cycles after reset release; pcout=0,2,4,6 on consecutive cycles, with ir matching.
- Memory with 3-cycle ack latency -> imem_addr stable and imem_req high for 3 cycles per fetch; one valid instruction every 3 cycles.
- stall=1 for 4 cycles with a zero-wait memory -> ir/pcout frozen; skid fills; imem_req=0 in FULL. After release, instructions appear in order 4, 6, 8 with none lost or duplicated.
- redirect with redirect_pc=16'h0100 during a pending 3-cycle request at 16'h0008 -> imem_addr held at 0x0008 until ack; that data is never presented; next imem_addr=0x0100; next valid pcout=0x0100.
- redirect coincident with imem_ack and with stall=1, skid full -> valid=0 next cycle; skid empty; fetch resumes at redirect_pc; stale data never appears.
- Start at RESET_PC=16'hFFFC -> pcout sequence FFFC, FFFE, 0000; reset pulsed mid-request -> outputs zero immediately and fetch restarts at FFFC.

Source files
------------

// File: rtl/fetch_cycle_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// datapath widths and the NOP word.
package fetch_cycle_pkg;

  localparam int unsigned INST_W    = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned REG_IDX_W = 4;

  localparam logic [INST_W-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc, valid} holding register between pipeline stages.
// Flush wins over push; push wins over pop so a same-cycle pop+push refills.
module fetch_skid_buffer
  import fetch_cycle_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      inst_d  = inst_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_q  <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: owns the PC, drives a req/ack instruction memory,
// buffers one returned word in a skid register and handles redirects.
module fetch_cycle
  import fetch_cycle_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 16'd2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] pcout,
  output logic              valid
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  logic              skid_push, skid_pop, skid_flush, skid_valid, skid_next;
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_pc;
  logic              consume, out_free, ack_accept;

  fetch_skid_buffer u_skid (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .inst_i  (imem_rdata),
    .pc_i    (addr_q),
    .inst_o  (skid_inst),
    .pc_o    (skid_pc),
    .valid_o (skid_valid)
  );

  assign consume    = valid_q && !stall;
  assign out_free   = !valid_q || consume;
  assign ack_accept = (state_q == ST_REQ) && imem_ack;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    target_d   = target_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;
    skid_next  = skid_valid;

    if (redirect) begin
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      target_d   = redirect_pc;
      unique case (state_q)
        // An outstanding request must complete on the old address first.
        ST_REQ, ST_DROP: begin
          if (imem_ack) begin
            state_d = ST_REQ;
            addr_d  = redirect_pc;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_REQ;
          addr_d  = redirect_pc;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          addr_d  = RESET_PC;
        end
        ST_DROP: begin
          if (imem_ack) begin
            state_d = ST_REQ;
            addr_d  = target_q;
          end
        end
        default: begin
          // Skid drains ahead of any newly returned word to keep program order.
          skid_pop = skid_valid && out_free;
          if (skid_pop) begin
            ir_d    = skid_inst;
            pc_d    = skid_pc;
            valid_d = 1'b1;
          end else if (ack_accept && out_free) begin
            ir_d    = imem_rdata;
            pc_d    = addr_q;
            valid_d = 1'b1;
          end else if (consume) begin
            valid_d = 1'b0;
          end
          skid_push = ack_accept && (!out_free || skid_pop);
          if (ack_accept) addr_d = addr_q + PC_INC;
          skid_next = skid_push || (skid_valid && !skid_pop);
          state_d   = (valid_d && skid_next) ? ST_FULL : ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      ir_q     <= NOP;
      pc_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign pcout     = pc_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: memory model returns addr ^ 16'hA5A5 with
// a configurable ack latency; a second instance covers the FFFC reset PC.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req, imem_ack, valid;
  logic [15:0] imem_addr, imem_rdata, ir, pcout;
  logic        force_ack = 1'b0;
  int unsigned lat = 0;
  int unsigned wait_cnt;

  logic        reset2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [15:0] redirect_pc2 = 16'h0000;
  logic        imem_req2, imem_ack2, valid2;
  logic [15:0] imem_addr2, imem_rdata2, ir2, pcout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_cycle dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir), .pcout(pcout),
    .valid(valid)
  );

  fetch_cycle #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(stall2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .ir(ir2), .pcout(pcout2),
    .valid(valid2)
  );

  assign imem_ack    = force_ack | (imem_req && (lat == 0 || wait_cnt == lat - 1));
  assign imem_rdata  = imem_addr ^ 16'hA5A5;
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2 ^ 16'hA5A5;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int unsigned l);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; force_ack = 1'b0; lat = l;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL rst_ir got %h exp 0000", ir); end
    checks++; if (pcout !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h exp 0000", pcout); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] exp_pc[4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    logic [15:0] exp_ir[4] = '{16'hA5A5, 16'hA5A7, 16'hA5A1, 16'hA5A3};
    apply_reset(0);
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zw_idle_valid got %b exp 0", valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req got %b exp 1", imem_req); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || pcout !== exp_pc[i] || ir !== exp_ir[i]) begin
        errors++;
        $display("FAIL zw_seq%0d got v=%b pc=%h ir=%h exp v=1 pc=%h ir=%h", i, valid, pcout, ir, exp_pc[i], exp_ir[i]);
      end
    end
  endtask

  task automatic test_latency3();
    logic [15:0] exp_addr[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0002, 16'h0004};
    logic        exp_v[7]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp_pc[7]   = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002};
    apply_reset(3);
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr[i] || valid !== exp_v[i] ||
          (exp_v[i] && pcout !== exp_pc[i])) begin
        errors++;
        $display("FAIL lat3_c%0d got req=%b addr=%h v=%b pc=%h exp req=1 addr=%h v=%b pc=%h",
                 i, imem_req, imem_addr, valid, pcout, exp_addr[i], exp_v[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_pc[3] = '{16'h0004, 16'h0006, 16'h0008};
    logic [15:0] exp_ir[3] = '{16'hA5A1, 16'hA5A3, 16'hA5AD};
    apply_reset(0);
    repeat (3) step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || pcout !== 16'h0002 || ir !== 16'hA5A7 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b pc=%h ir=%h req=%b exp v=1 pc=0002 ir=a5a7 req=0",
                 i, valid, pcout, ir, imem_req);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || pcout !== exp_pc[i] || ir !== exp_ir[i]) begin
        errors++;
        $display("FAIL stall_drain%0d got v=%b pc=%h ir=%h exp v=1 pc=%h ir=%h", i, valid, pcout, ir, exp_pc[i], exp_ir[i]);
      end
    end
  endtask

  task automatic test_redirect_drop();
    logic [15:0] exp_addr[6] = '{16'h0008, 16'h0008, 16'h0100, 16'h0100, 16'h0100, 16'h0102};
    logic        exp_v[6]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit found = 1'b0;
    apply_reset(3);
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_addr === 16'h0008) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL drop_reach got addr=%h exp 0008 within 40 cycles", imem_addr); end
    redirect = 1'b1; redirect_pc = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      step();
      redirect = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr[i] || valid !== exp_v[i]) begin
        errors++;
        $display("FAIL drop_c%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=%b",
                 i, imem_req, imem_addr, valid, exp_addr[i], exp_v[i]);
      end
    end
    checks++;
    if (pcout !== 16'h0100 || ir !== 16'hA4A5) begin
      errors++; $display("FAIL drop_first got pc=%h ir=%h exp pc=0100 ir=a4a5", pcout, ir);
    end
  endtask

  task automatic test_redirect_ack();
    apply_reset(0);
    repeat (3) step();
    stall = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rack_full got req=%b exp 0", imem_req); end
    redirect = 1'b1; redirect_pc = 16'h0200; force_ack = 1'b1;
    step();
    redirect = 1'b0; force_ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || imem_addr !== 16'h0200 || imem_req !== 1'b1) begin
      errors++; $display("FAIL rack_flush got v=%b addr=%h req=%b exp v=0 addr=0200 req=1", valid, imem_addr, imem_req);
    end
    stall = 1'b0;
    step();
    checks++;
    if (valid !== 1'b1 || pcout !== 16'h0200 || ir !== 16'hA7A5) begin
      errors++; $display("FAIL rack_first got v=%b pc=%h ir=%h exp v=1 pc=0200 ir=a7a5", valid, pcout, ir);
    end
    step();
    checks++;
    if (valid !== 1'b1 || pcout !== 16'h0202 || ir !== 16'hA7A7) begin
      errors++; $display("FAIL rack_second got v=%b pc=%h ir=%h exp v=1 pc=0202 ir=a7a7", valid, pcout, ir);
    end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0300;
    step();
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (valid !== 1'b0 || imem_addr !== 16'h0300) begin
      errors++; $display("FAIL rack_reqack got v=%b addr=%h exp v=0 addr=0300", valid, imem_addr);
    end
    step();
    checks++;
    if (valid !== 1'b1 || pcout !== 16'h0300 || ir !== 16'hA6A5) begin
      errors++; $display("FAIL rack_resume0 got v=%b pc=%h ir=%h exp v=1 pc=0300 ir=a6a5", valid, pcout, ir);
    end
    step();
    checks++;
    if (valid !== 1'b1 || pcout !== 16'h0302 || ir !== 16'hA6A7) begin
      errors++; $display("FAIL rack_resume1 got v=%b pc=%h ir=%h exp v=1 pc=0302 ir=a6a7", valid, pcout, ir);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc[3] = '{16'hFFFC, 16'hFFFE, 16'h0000};
    logic [15:0] exp_ir[3] = '{16'h5A59, 16'h5A5B, 16'hA5A5};
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset2 = 1'b0;
    step();
    checks++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 16'hFFFC) begin
      errors++; $display("FAIL wrap_start got req=%b addr=%h exp req=1 addr=fffc", imem_req2, imem_addr2);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid2 !== 1'b1 || pcout2 !== exp_pc[i] || ir2 !== exp_ir[i]) begin
        errors++;
        $display("FAIL wrap_seq%0d got v=%b pc=%h ir=%h exp v=1 pc=%h ir=%h", i, valid2, pcout2, ir2, exp_pc[i], exp_ir[i]);
      end
    end
    reset2 = 1'b1;
    #1;
    checks++;
    if (ir2 !== 16'h0000 || pcout2 !== 16'h0000 || valid2 !== 1'b0 || imem_req2 !== 1'b0 || imem_addr2 !== 16'hFFFC) begin
      errors++;
      $display("FAIL wrap_async_rst got ir=%h pc=%h v=%b req=%b addr=%h exp ir=0000 pc=0000 v=0 req=0 addr=fffc",
               ir2, pcout2, valid2, imem_req2, imem_addr2);
    end
    step();
    reset2 = 1'b0;
    step();
    checks++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 16'hFFFC || valid2 !== 1'b0) begin
      errors++; $display("FAIL wrap_restart got req=%b addr=%h v=%b exp req=1 addr=fffc v=0", imem_req2, imem_addr2, valid2);
    end
    step();
    checks++;
    if (valid2 !== 1'b1 || pcout2 !== 16'hFFFC || ir2 !== 16'h5A59) begin
      errors++; $display("FAIL wrap_refetch got v=%b pc=%h ir=%h exp v=1 pc=fffc ir=5a59", valid2, pcout2, ir2);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency3();
    test_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
